instruction_cache: RTL and testbench

//   Set-associative, read-only instruction cache tag/data store with a line-refill controller.

---
 rtl/instruction_cache.sv | 137 +++++++++++++
 tb/tb_instruction_cache.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Set-associative, read-only instruction cache tag/data store with a
// line-refill controller. Lookups are combinational; on a miss the controller
// latches the set and a victim way, then accepts one refill word per cycle
// and validates the line once its final word has been written.

module instruction_cache #(
    parameter int DATA_LENGTH = 32,
    parameter int CACHE_SIZE  = 32 * 1024,
    parameter int LINE_SIZE   = 64,
    parameter int WAYS        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [31:0]            addr,
    output logic                   miss_detected,
    input  logic                   refill_valid,
    input  logic [DATA_LENGTH-1:0] refill_data,
    output logic                   refill_complete
);

    localparam int WORDS = LINE_SIZE / (DATA_LENGTH / 8);
    localparam int SETS  = CACHE_SIZE / (LINE_SIZE * WAYS);
    localparam int OFF   = $clog2(LINE_SIZE);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = 32 - IDX - OFF;
    localparam int WAY_W = $clog2(WAYS);
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    // Storage
    logic [DATA_LENGTH-1:0]       data_array [SETS][WAYS][WORDS];
    logic [TAG-1:0]               tag_array  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]    valid;
    logic [SETS-1:0][WAY_W-1:0]   rr;

    // Refill controller state
    state_t                       state;
    logic [CNT_W-1:0]             cnt;
    logic [IDX-1:0]               set_index;
    logic [WAY_W-1:0]             replace_way;
    logic [TAG-1:0]               refill_tag;

    // Address decode; the byte offset does not take part in a tag lookup
    logic [IDX-1:0]               lookup_index;
    logic [TAG-1:0]               lookup_tag;
    logic                         unused_offset;

    assign lookup_index  = addr[OFF +: IDX];
    assign lookup_tag    = addr[31 -: TAG];
    assign unused_offset = &{1'b0, addr[OFF-1:0]};

    logic                         hit;
    logic [WAY_W-1:0]             victim_way;
    logic                         last_accept;

    assign last_accept = (state == REFILL) && refill_valid && (cnt == LAST_WORD);

    // Tag compare across all ways of the addressed set
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        hit = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[lookup_index][w] && tag_array[lookup_index][w] == lookup_tag) begin
                hit = 1'b1;
            end
        end
    end

    // Victim choice: lowest-numbered invalid way, otherwise the set's round-robin pointer
    always_comb begin
        victim_way = rr[lookup_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[lookup_index][w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    assign miss_detected = (state == REFILL) || !hit;

    // Refill FSM, valid bits, round-robin pointers and the completion pulse
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst || flush) begin
            state           <= IDLE;
            cnt             <= '0;
            refill_complete <= 1'b0;
            valid           <= '0;
            rr              <= '0;
        end else begin
            refill_complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (!hit) begin
                        set_index            <= lookup_index;
                        refill_tag           <= lookup_tag;
                        replace_way          <= victim_way;
                        rr[lookup_index]     <= rr[lookup_index] + WAY_W'(1);
                        cnt                  <= '0;
                        state                <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_valid) begin
                        if (cnt == LAST_WORD) begin
                            cnt                           <= '0;
                            valid[set_index][replace_way] <= 1'b1;
                            refill_complete               <= 1'b1;
                            state                         <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag writes during refill; aborted refills write nothing further
    always_ff @(posedge clk) begin
        // NOTE: the arrays are deliberately not reset; the valid bits alone decide what is live.
        if (!rst && !flush && state == REFILL && refill_valid) begin
            data_array[set_index][replace_way][cnt] <= refill_data;
            if (last_accept) begin
                tag_array[set_index][replace_way] <= refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: reset state, line fill, lookup
// tables, round-robin eviction, flush (idle, mid-refill, on last word)
// and refill stalls.

module tb_instruction_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] addr;
    logic        miss_detected;
    logic        refill_valid;
    logic [31:0] refill_data;
    logic        refill_complete;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic        exp_miss;
    } lookup_vec_t;

    lookup_vec_t vec1 [5];
    lookup_vec_t vec2 [5];

    instruction_cache dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .addr            (addr),
        .miss_detected   (miss_detected),
        .refill_valid    (refill_valid),
        .refill_data     (refill_data),
        .refill_complete (refill_complete)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // combinational lookups only, no clock edge taken
    task automatic run_lookups(input lookup_vec_t v [5], input string tag);
        for (int i = 0; i < 5; i++) begin
            addr = v[i].a;
            #1;
            check($sformatf("%s_lookup_%0h", tag, v[i].a), 64'(miss_detected), 64'(v[i].exp_miss));
        end
    endtask

    // Miss on a, refill 16 words (data = a + j), optional stall of stall_len
    // cycles after stall_at words. Checks victim way and completion timing.
    task automatic fill_line(input logic [31:0] a, input int exp_way,
                             input int stall_at, input int stall_len);
        int edges;
        addr = a;
        #1;
        check("fill_miss_before", 64'(miss_detected), 64'd1);
        step();
        check("fill_state_refill", 64'(dut.state), 64'd1);
        check("fill_replace_way", 64'(dut.replace_way), 64'(exp_way));
        edges = 0;
        for (int j = 0; j < 16; j++) begin
            if (j == stall_at) begin
                refill_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    edges++;
                    check("stall_cnt_hold", 64'(dut.cnt), 64'(stall_at));
                    check("stall_miss", 64'(miss_detected), 64'd1);
                end
            end
            refill_valid = 1'b1;
            refill_data  = a + 32'(j);
            step();
            edges++;
            if (j < 15 && (j % 4) == 0) check("fill_no_early_complete", 64'(refill_complete), 64'd0);
        end
        refill_valid = 1'b0;
        check("fill_complete_pulse", 64'(refill_complete), 64'd1);
        check("fill_latency", 64'(edges), 64'(16 + stall_len));
        check("fill_hit_after", 64'(miss_detected), 64'd0);
    endtask

    initial begin
        vec1[0] = '{32'h0000_1000, 1'b0};
        vec1[1] = '{32'h0000_103C, 1'b0};
        vec1[2] = '{32'h0000_1040, 1'b1};
        vec1[3] = '{32'h0000_2000, 1'b1};
        vec1[4] = '{32'h0000_0000, 1'b1};
        vec2[0] = '{32'h0000_1000, 1'b1};
        vec2[1] = '{32'h0000_2000, 1'b0};
        vec2[2] = '{32'h0000_9000, 1'b0};
        vec2[3] = '{32'h0000_8004, 1'b0};
        vec2[4] = '{32'h0000_A000, 1'b1};

        rst = 1'b1; flush = 1'b0; refill_valid = 1'b0; refill_data = '0;
        addr = 32'h0000_1000;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_miss", 64'(miss_detected), 64'd1);
        check("reset_complete", 64'(refill_complete), 64'd0);
        check("reset_state", 64'(dut.state), 64'd0);

        // First miss and full line fill with data 0..15
        step();
        check("miss_after_edge", 64'(miss_detected), 64'd1);
        check("first_state", 64'(dut.state), 64'd1);
        check("first_set_index", 64'(dut.set_index), 64'h0);
        check("first_replace_way", 64'(dut.replace_way), 64'd0);
        addr = 32'h0000_5000;  // ignored during refill
        for (int j = 0; j < 16; j++) begin
            refill_valid = 1'b1;
            refill_data  = 32'(j);
            step();
            if (j < 15) check("refill_in_progress_miss", 64'(miss_detected), 64'd1);
        end
        refill_valid = 1'b0;
        addr = 32'h0000_1000;
        #1;
        check("first_complete", 64'(refill_complete), 64'd1);
        check("first_hit", 64'(miss_detected), 64'd0);
        step();
        check("first_complete_drop", 64'(refill_complete), 64'd0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("data_word_%0d", j), 64'(dut.data_array[0][0][j]), 64'(j));
        end

        run_lookups(vec1, "t1");

        // Fill ways 1..7 of set 0, then the 9th tag evicts way 0
        for (int k = 2; k <= 8; k++) begin
            fill_line(32'(k) << 12, k - 1, 99, 0);
        end
        fill_line(32'h0000_9000, 0, 99, 0);
        run_lookups(vec2, "t2");

        // Flush while idle
        addr = 32'h0000_9000;
        #1;
        check("pre_flush_hit", 64'(miss_detected), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        addr = 32'h0000_1000;
        #1;
        check("post_flush_miss", 64'(miss_detected), 64'd1);

        // Flush after word 5 of a refill
        step();
        for (int j = 0; j < 6; j++) begin
            refill_valid = 1'b1;
            refill_data  = 32'(j);
            step();
        end
        flush = 1'b1;
        refill_data = 32'd6;
        step();
        flush = 1'b0;
        refill_valid = 1'b0;
        check("midflush_state", 64'(dut.state), 64'd0);
        check("midflush_complete", 64'(refill_complete), 64'd0);
        check("midflush_miss", 64'(miss_detected), 64'd1);

        // Flush coinciding with the last word: line stays invalid
        step();
        for (int j = 0; j < 16; j++) begin
            refill_valid = 1'b1;
            refill_data  = 32'(j);
            if (j == 15) flush = 1'b1;
            step();
        end
        flush = 1'b0;
        refill_valid = 1'b0;
        check("lastflush_complete", 64'(refill_complete), 64'd0);
        check("lastflush_miss", 64'(miss_detected), 64'd1);
        check("lastflush_state", 64'(dut.state), 64'd0);

        // Stall 3 cycles after word 7; completion delayed by exactly 3
        fill_line(32'h0000_1000, 0, 8, 3);
        step();
        check("stall_complete_drop", 64'(refill_complete), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
